// File: rtl/hmac_block_feeder.sv
// hmac_block_feeder
// Upstream sequencer for the HMAC core. Collects a pre-padded message as
// 32-bit words into 1024-bit blocks. Each block is handed to the core with a
// one-cycle init (first block) or next (later blocks) command and is held
// stable while the core works. When the last block completes, the core's
// 512-bit tag is latched for the register interface.
//
// Build option: define HMAC_FEEDER_DBLBUF_EN to get two ping-pong block
// buffers. The next block is then collected while the core is busy.
//
// Ports:
//   clk, reset_n (async, active-low), zeroize (sync clear of all state)
//   start, mode_in                        : begin a message, 0=384 / 1=512
//   in_valid/in_ready/in_data/in_last     : message word stream
//   core_init/core_next/core_mode/core_block/core_ready/
//   core_tag_valid/core_tag               : HMAC core command interface
//   blk_cnt, busy, done, tag_out, tag_valid_out : status and result
module hmac_block_feeder #(
    parameter int WORD_W    = 32,
    parameter int BLK_WORDS = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              zeroize,
    input  logic              start,
    input  logic              mode_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              core_init,
    output logic              core_next,
    output logic              core_mode,
    output logic [1023:0]     core_block,
    input  logic              core_ready,
    input  logic              core_tag_valid,
    input  logic [511:0]      core_tag,
    output logic [15:0]       blk_cnt,
    output logic              busy,
    output logic              done,
    output logic [511:0]      tag_out,
    output logic              tag_valid_out
);
    localparam int IDX_W = $clog2(BLK_WORDS);

    generate
        if (WORD_W != 32 || BLK_WORDS != 1024 / WORD_W) begin : g_bad_cfg
            $error("hmac_block_feeder supports only WORD_W=32, BLK_WORDS=32");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_first;
    logic               r_last;
    logic               r_mode;
    logic [15:0]        r_blk_cnt;
    logic [511:0]       r_tag;
    logic               r_tag_valid;
    logic               r_done;
    logic               w_fill_wr;
    logic               w_word_wr;
    logic               w_cmd;
    logic               w_tag_latch;
    logic               w_start_acc;
    logic               w_last_word;

`ifdef HMAC_FEEDER_DBLBUF_EN
    localparam int NBUF = 2;
    logic               r_act;        // buffer currently presented to the core
    logic               r_pend_full;  // inactive buffer holds a complete block
    logic               r_pend_last;
    logic               w_pf_ok;
    logic               w_pf_wr;
    logic               w_pend_now;
    logic               w_pf_last;
    logic               w_wsel;
    logic               w_swap;
`else
    localparam int NBUF = 1;
`endif

    logic [NBUF-1:0]    w_buf_we;
    logic [1023:0]      w_blk [NBUF];

    assign w_last_word = (r_idx == IDX_W'(BLK_WORDS - 1));

`ifdef HMAC_FEEDER_DBLBUF_EN
    // Prefetch into the idle buffer while the core chews on the active one,
    // but only when more blocks of this message are still to come.
    assign w_pf_ok    = !zeroize && !r_last && !r_pend_full &&
                        (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE);
    assign w_pf_wr    = w_pf_ok && in_valid;
    // A block that completes in the very cycle the core frees up counts as ready.
    assign w_pend_now = r_pend_full || (w_pf_wr && w_last_word);
    assign w_pf_last  = r_pend_full ? r_pend_last : in_last;
    assign w_wsel     = (r_state == S_FILL) ? r_act : ~r_act;
    assign w_word_wr  = w_fill_wr || w_pf_wr;
    assign w_buf_we   = {w_word_wr && w_wsel, w_word_wr && !w_wsel};
    assign in_ready   = (r_state == S_FILL && !zeroize) || w_pf_ok;
    assign core_block = w_blk[r_act];
`else
    assign w_word_wr  = w_fill_wr;
    assign w_buf_we   = w_fill_wr;
    assign in_ready   = (r_state == S_FILL) && !zeroize;
    assign core_block = w_blk[0];
`endif

    // Commands are decoded straight from ISSUE so they fire the cycle the
    // core reports ready; leaving ISSUE on that edge makes them one cycle long.
    assign core_init     = w_cmd && r_first;
    assign core_next     = w_cmd && !r_first;
    assign core_mode     = r_mode;
    assign blk_cnt       = r_blk_cnt;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign tag_out       = r_tag;
    assign tag_valid_out = r_tag_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_state <= S_IDLE;
        else              r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_fill_wr    = 1'b0;
        w_cmd        = 1'b0;
        w_tag_latch  = 1'b0;
        w_start_acc  = 1'b0;
`ifdef HMAC_FEEDER_DBLBUF_EN
        w_swap       = 1'b0;
`endif
        if (zeroize) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_start_acc  = 1'b1;
                        w_state_next = S_FILL;
                    end
                end
                S_FILL: begin
                    if (start) begin
                        w_start_acc = 1'b1;   // restart; this cycle's word is dropped
                    end else if (in_valid) begin
                        w_fill_wr = 1'b1;
                        if (w_last_word) w_state_next = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (core_ready) begin
                        w_cmd        = 1'b1;
                        w_state_next = S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (!core_ready) w_state_next = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (core_ready) begin
                        if (!r_last) begin
`ifdef HMAC_FEEDER_DBLBUF_EN
                            w_swap       = 1'b1;
                            w_state_next = w_pend_now ? S_ISSUE : S_FILL;
`else
                            w_state_next = S_FILL;
`endif
                        end else if (core_tag_valid) begin
                            w_tag_latch  = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || zeroize) begin
            r_idx       <= '0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_mode      <= 1'b0;
            r_blk_cnt   <= '0;
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_tag_latch;
            if (w_start_acc) begin
                r_idx       <= '0;
                r_mode      <= mode_in;
                r_first     <= 1'b1;
                r_blk_cnt   <= '0;
                r_tag_valid <= 1'b0;
            end else begin
                if (w_word_wr) r_idx <= r_idx + 1'b1;   // wraps after the 32nd word
                if (w_fill_wr && w_last_word) r_last <= in_last;
`ifdef HMAC_FEEDER_DBLBUF_EN
                if (w_swap && w_pend_now) r_last <= w_pf_last;
`endif
                if (w_cmd) begin
                    r_first <= 1'b0;
                    if (r_blk_cnt != 16'hFFFF) r_blk_cnt <= r_blk_cnt + 16'd1;
                end
                if (w_tag_latch) begin
                    r_tag       <= core_tag;
                    r_tag_valid <= 1'b1;
                end
            end
        end
    end

`ifdef HMAC_FEEDER_DBLBUF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || zeroize) begin
            r_act       <= 1'b0;
            r_pend_full <= 1'b0;
            r_pend_last <= 1'b0;
        end else if (w_start_acc) begin
            r_pend_full <= 1'b0;
        end else begin
            if (w_pf_wr && w_last_word) begin
                r_pend_full <= 1'b1;
                r_pend_last <= in_last;
            end
            if (w_swap) begin
                r_act       <= ~r_act;
                r_pend_full <= 1'b0;
            end
        end
    end
`endif

    // Word storage; word 0 of a block sits in the top 32 bits.
    genvar gb, gi;
    generate
        for (gb = 0; gb < NBUF; gb++) begin : g_buf
            for (gi = 0; gi < BLK_WORDS; gi++) begin : g_word
                logic [WORD_W-1:0] r_w;
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n || zeroize)
                        r_w <= '0;
                    else if (w_buf_we[gb] && r_idx == IDX_W'(gi))
                        r_w <= in_data;
                end
                assign w_blk[gb][1023 - WORD_W*gi -: WORD_W] = r_w;
            end
        end
    endgenerate
endmodule
